store_buffer: RTL and testbench
===============================

# store_buffer

Word-granular FIFO write buffer between the execute stage and the data memory. It accepts stores from the core, holds up to DEPTH of them, and drains one per cycle into the data memory write port whenever the memory accepts. Loads consult the buffer in the same cycle: the youngest pending store to the same word is forwarded, so software never observes a stale memory value.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- IDX_W, 10, word-index width used for address matching (address[IDX_W+1:2])

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately
- st_valid  in  1  store request this cycle
- st_addr  in  32  store byte address; bits [1:0] ignored
- st_data  in  32  store word
- st_pc  in  32  pc of the storing instruction, carried for trace
- st_ready  out  1  buffer can accept; a store is taken iff st_valid && st_ready
- ld_addr  in  32  load byte address for lookup
- ld_hit  out  1  a pending entry matches ld_addr
- ld_data  out  32  data of youngest matching entry; 0 when !ld_hit
- dm_we  out  1  head entry presented to memory
- dm_addr  out  32  head entry address, bits [1:0] forced 0
- dm_data  out  32  head entry data
- dm_pc  out  32  head entry pc
- dm_ready  in  1  memory consumes head at this edge iff dm_we && dm_ready
- count  out  clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

## Operation
- Storage: DEPTH entries of {word index, data, pc}, circular head/tail pointers plus count register.
- Enqueue: on st_valid && st_ready, write entry at tail, tail+1 mod DEPTH.
- Dequeue: on dm_we && dm_ready, head+1 mod DEPTH.
- st_ready = (count != DEPTH); depends only on registered count, never on dm_ready. When full, a same-cycle drain does not admit a store.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- dm_we = !empty; dm_addr/dm_data/dm_pc are the head entry, 0 when empty.
- Forwarding: combinational compare of ld_addr[IDX_W+1:2] against every occupied entry; select the youngest (closest to tail). The head entry being drained this cycle still forwards. The store offered on st_* this cycle does not forward.
- Duplicate addresses are kept as separate entries; no coalescing. Memory writes occur in program order.
- Reset (reset==0, any time): count=0, head=tail=0; pending stores discarded, not written. Entry contents need not be cleared.

## Timing
- Reset outputs: st_ready=1, dm_we=0, dm_addr=dm_data=dm_pc=0, ld_hit=0, ld_data=0, count=0, empty=1.
- Store accepted at edge N: visible to ld_hit from cycle N+1, on dm_we from cycle N+1 if buffer was empty; written to memory at the first edge with dm_ready=1 after that.
- Minimum store-to-memory latency: 1 cycle in buffer. Throughput: one store per cycle with dm_ready held high.
- ld_hit/ld_data: zero-cycle combinational from ld_addr and registered state.
- Pointer wrap: DEPTH-1 to 0; count never exceeds DEPTH, never underflows.

## Structure
- Shared package store_buffer_pkg: DEPTH default, IDX_W default, entry struct typedef {idx, data, pc}, word_index(addr) function.
- One sub-module: store_buffer_match — takes entry array, valid mask, tail pointer, lookup index; returns hit and youngest-match data via tail-relative priority scan.
- FIFO control stays in store_buffer.

## Test plan
- Reset mid-fill: enqueue 3 stores with dm_ready=0, pull reset low -> count=0, empty=1, dm_we=0 asynchronously, ld_hit=0 for those addresses; memory never written.
- Fill and stall: dm_ready=0, offer 5 stores 0x10..0x50 -> first 4 accepted, st_ready=0 at count=4, fifth held; raise dm_ready -> dm_addr 0x10,0x20,0x30,0x40 then 0x50 on consecutive cycles.
- Full with drain: count=4, dm_ready=1, st_valid=1 -> store refused that cycle, count 3 next cycle, accepted the cycle after.
- Youngest forward: stores 0x100<=0x11, 0x104<=0x22, 0x102<=0x33 -> ld_addr=0x100 gives ld_hit=1, ld_data=0x33; ld_addr=0x108 gives ld_hit=0, ld_data=0.
- Wrap-around: 10 stores with dm_ready toggling each cycle -> memory receives all 10 in order, count never >4, forwarding correct across pointer wrap.
- Same-cycle store not forwarded: empty buffer, st_valid with st_addr=ld_addr=0x200 -> ld_hit=0 that cycle, ld_hit=1, ld_data=st_data next cycle.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared definitions for the store buffer: default geometry, the entry record
// kept for every pending store, and the byte-address to word-address helper.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;   // default number of entries (power of two, 2..16)
    localparam int SB_IDX_W = 10;  // default word-index width used for load matching

    // One pending store. The full word address is kept so the memory write
    // goes to the right place; only its low IDX_W bits take part in matching.
    typedef struct packed {
        logic [29:0] idx;   // word address, byte address bits [31:2]
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

    // Byte address -> word address (bits [1:0] are dropped).
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage : store_buffer_pkg

// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Groups the store, load-lookup and memory-drain signals of the store buffer.
//   slave  : the buffer side (takes st_*, ld_addr, dm_ready; drives the rest)
//   master : the core/memory side (the opposite directions)
// -----------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int DEPTH = store_buffer_pkg::SB_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // store port from the execute stage
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [31:0]      st_pc;
    logic             st_ready;
    // load lookup
    logic [31:0]      ld_addr;
    logic             ld_hit;
    logic [31:0]      ld_data;
    // data-memory write port
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_data;
    logic [31:0]      dm_pc;
    logic             dm_ready;
    // status
    logic [CNT_W-1:0] count;
    logic             empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_addr, dm_ready,
        output st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_data, dm_pc, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_addr, dm_ready,
        input  st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_data, dm_pc, count, empty
    );

endinterface : store_buffer_if

// File: rtl/store_buffer_match.sv
// -----------------------------------------------------------------------------
// store_buffer_match
// Combinational load-forwarding lookup. Compares a word index against every
// occupied entry and returns the data of the youngest match.
//   entries_i : entry array (indexed by physical slot)
//   valid_i   : occupied-slot mask
//   tail_i    : next slot to be written; tail_i-1 is the youngest entry
//   lk_idx_i  : word index of the load
//   hit_o     : some occupied entry matches
//   data_o    : data of the youngest matching entry, 0 when no hit
// -----------------------------------------------------------------------------
module store_buffer_match import store_buffer_pkg::*; #(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDX_W = SB_IDX_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t        entries_i [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [PTR_W-1:0] tail_i,
    input  logic [IDX_W-1:0] lk_idx_i,
    output logic             hit_o,
    output logic [31:0]      data_o
);

    logic [PTR_W-1:0] pos;
    logic             unused_bits;

    // Scan from the oldest slot (tail-DEPTH) to the youngest (tail-1); a later
    // match overwrites an earlier one, so the youngest match wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a
        // path that skips the assignment infers a latch.
        hit_o  = 1'b0;
        data_o = '0;
        pos    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            pos = tail_i - PTR_W'(k);
            if (valid_i[pos] && (entries_i[pos].idx[IDX_W-1:0] == lk_idx_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[pos].data;
            end
        end
    end

    // Upper address bits and pc are carried for the memory side only.
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ (^{entries_i[i].idx[29:IDX_W], entries_i[i].pc});
        end
    end

endmodule : store_buffer_match

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Word-granular FIFO write buffer between execute and data memory. Accepts up
// to DEPTH stores, drains the oldest one whenever memory is ready, and
// forwards the youngest pending store to a matching load in the same cycle.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low; discards all pending stores
//   sb    : store / load-lookup / memory-drain bundle (slave side)
// -----------------------------------------------------------------------------
module store_buffer import store_buffer_pkg::*; #(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDX_W = SB_IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    store_buffer_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] off;
    sb_entry_t        head_entry;
    logic             unused_bits;

    // ------------------------------------------------------------------ control
    // Readiness looks only at the registered count: a full buffer refuses a
    // store even in a cycle where the head is being drained.
    assign empty       = (count_q == '0);
    assign sb.st_ready = (count_q != CNT_W'(DEPTH));
    assign enq         = sb.st_valid && sb.st_ready;
    assign deq         = !empty && sb.dm_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + 1'b1;   // power-of-two depth: wraps naturally
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; occupancy is defined by
    // head/count alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{idx: word_index(sb.st_addr), data: sb.st_data, pc: sb.st_pc};
        end
    end

    // ------------------------------------------------------------ memory side
    assign head_entry = mem_q[head_q];
    assign sb.dm_we   = !empty;
    assign sb.dm_addr = empty ? '0 : {head_entry.idx, 2'b00};
    assign sb.dm_data = empty ? '0 : head_entry.data;
    assign sb.dm_pc   = empty ? '0 : head_entry.pc;
    assign sb.count   = count_q;
    assign sb.empty   = empty;

    // -------------------------------------------------------------- forwarding
    // A slot is occupied when its distance from head is below count. The head
    // slot stays occupied until the edge that drains it, so it still forwards.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head_q;
            valid[i] = ({1'b0, off} < count_q);
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_match (
        .entries_i (mem_q),
        .valid_i   (valid),
        .tail_i    (tail_q),
        .lk_idx_i  (sb.ld_addr[IDX_W+1:2]),
        .hit_o     (sb.ld_hit),
        .data_o    (sb.ld_data)
    );

    // Byte-offset bits and the load's upper address bits do not take part.
    assign unused_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0], sb.ld_addr[31:IDX_W+2]};

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer. A queue of pending stores serves as the
// reference: stores push at the back, memory writes pop the front, and loads
// search the queue for the last store to the same word.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int IDX_W = 10;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } st_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    st_t model_q [$];   // pending stores, oldest first
    st_t wr_exp  [$];   // memory writes the model expects, in order
    st_t wr_act  [$];   // memory writes the DUT actually performed

    store_buffer_if #(.DEPTH(DEPTH)) sb ();

    store_buffer #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .sb    (sb.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- reference model
    function automatic bit m_hit(input logic [31:0] a);
        foreach (model_q[i])
            if (model_q[i].addr[IDX_W+1:2] == a[IDX_W+1:2]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] a);
        logic [31:0] d = '0;
        foreach (model_q[i])
            if (model_q[i].addr[IDX_W+1:2] == a[IDX_W+1:2]) d = model_q[i].data;
        return d;
    endfunction

    function automatic st_t m_head();
        st_t z = '{32'h0, 32'h0, 32'h0};
        if (model_q.size() == 0) return z;
        return model_q[0];
    endfunction

    // One clock edge: record what the DUT writes, advance the model, then
    // return 1 ns after the edge so inputs change away from it.
    task automatic tick();
        bit enq, deq;
        enq = sb.st_valid && (model_q.size() < DEPTH) && rst_n;
        deq = (model_q.size() != 0) && sb.dm_ready && rst_n;
        if (sb.dm_we === 1'b1 && sb.dm_ready)
            wr_act.push_back('{sb.dm_addr, sb.dm_data, sb.dm_pc});
        if (deq) wr_exp.push_back(model_q.pop_front());
        if (enq) model_q.push_back('{{sb.st_addr[31:2], 2'b00}, sb.st_data, sb.st_pc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.st_valid = 1'b0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.st_pc    = '0;
        sb.ld_addr  = '0;
        sb.dm_ready = 1'b0;
    endtask

    task automatic drain();
        sb.st_valid = 1'b0;
        sb.dm_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && model_q.size() != 0; i++) tick();
        #1;
        vectors++;
        if (sb.empty !== 1'b1 || model_q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b model_pending=%0d required empty=1 pending=0",
                     sb.empty, model_q.size());
        end
        sb.dm_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        idle_inputs();
        #1;
        vectors += 9;
        if (sb.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", sb.st_ready); end
        if (sb.dm_we    !== 1'b0) begin errors++; $display("FAIL reset_dm_we: got %b want 0", sb.dm_we); end
        if (sb.dm_addr  !== '0)   begin errors++; $display("FAIL reset_dm_addr: got %h want 0", sb.dm_addr); end
        if (sb.dm_data  !== '0)   begin errors++; $display("FAIL reset_dm_data: got %h want 0", sb.dm_data); end
        if (sb.dm_pc    !== '0)   begin errors++; $display("FAIL reset_dm_pc: got %h want 0", sb.dm_pc); end
        if (sb.ld_hit   !== 1'b0) begin errors++; $display("FAIL reset_ld_hit: got %b want 0", sb.ld_hit); end
        if (sb.ld_data  !== '0)   begin errors++; $display("FAIL reset_ld_data: got %h want 0", sb.ld_data); end
        if (sb.count    !== '0)   begin errors++; $display("FAIL reset_count: got %0d want 0", sb.count); end
        if (sb.empty    !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", sb.empty); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] addrs [3];
        for (int i = 0; i < 3; i++) begin
            addrs[i]    = 32'h400 + 32'(4 * i);
            sb.st_valid = 1'b1;
            sb.st_addr  = addrs[i];
            sb.st_data  = $urandom;
            sb.st_pc    = $urandom;
            tick();
        end
        sb.st_valid = 1'b0;
        #1;
        vectors++;
        if (sb.count !== 3'd3) begin errors++; $display("FAIL midfill_count: got %0d want 3", sb.count); end
        #2;
        rst_n = 1'b0;           // between edges: must clear without a clock
        #1;
        model_q.delete();
        vectors += 3;
        if (sb.count !== '0)   begin errors++; $display("FAIL midfill_rst_count: got %0d want 0", sb.count); end
        if (sb.empty !== 1'b1) begin errors++; $display("FAIL midfill_rst_empty: got %b want 1", sb.empty); end
        if (sb.dm_we !== 1'b0) begin errors++; $display("FAIL midfill_rst_dm_we: got %b want 0", sb.dm_we); end
        for (int i = 0; i < 3; i++) begin
            sb.ld_addr = addrs[i];
            #1;
            vectors++;
            if (sb.ld_hit !== 1'b0) begin
                errors++;
                $display("FAIL midfill_rst_ld_hit: addr=%h got %b want 0", addrs[i], sb.ld_hit);
            end
        end
        sb.dm_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        vectors += 2;
        if (wr_act.size() != 0) begin errors++; $display("FAIL midfill_no_write: writes=%0d want 0", wr_act.size()); end
        if (sb.count !== '0)    begin errors++; $display("FAIL midfill_after_count: got %0d want 0", sb.count); end
        idle_inputs();
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_addr [5];
        bit          pending;
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_addr[i] = 32'h10 * (i + 1);
            sb.st_valid = 1'b1;
            sb.st_addr  = exp_addr[i];
            sb.st_data  = $urandom;
            sb.st_pc    = $urandom;
            #1;
            vectors += 2;
            if (sb.st_ready !== (i < 4)) begin
                errors++; $display("FAIL stall_st_ready: store %0d got %b want %b", i, sb.st_ready, (i < 4));
            end
            if (sb.count !== CNT_W'(i < 4 ? i : 4)) begin
                errors++; $display("FAIL stall_count: store %0d got %0d want %0d", i, sb.count, (i < 4 ? i : 4));
            end
            if (i < 4) tick();
        end
        pending     = 1'b1;       // 0x50 still offered
        sb.dm_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors += 2;
            if (sb.dm_we !== 1'b1) begin errors++; $display("FAIL stall_dm_we: cycle %0d got %b want 1", k, sb.dm_we); end
            if (sb.dm_addr !== exp_addr[k]) begin
                errors++; $display("FAIL stall_order: cycle %0d dm_addr=%h want %h", k, sb.dm_addr, exp_addr[k]);
            end
            if (pending && model_q.size() < DEPTH) pending = 1'b0;
            tick();
            if (!pending) sb.st_valid = 1'b0;
        end
        #1;
        vectors++;
        if (sb.empty !== 1'b1) begin errors++; $display("FAIL stall_final_empty: got %b want 1", sb.empty); end
        idle_inputs();
    endtask

    task automatic test_full_drain();
        sb.dm_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = 32'h600 + 32'(4 * i);
            sb.st_data  = $urandom;
            sb.st_pc    = $urandom;
            tick();
        end
        sb.st_addr  = 32'h700;
        sb.st_data  = 32'hFEED_0700;
        sb.ld_addr  = 32'h700;
        sb.dm_ready = 1'b1;
        #1;
        vectors += 2;
        if (sb.count !== 3'd4)    begin errors++; $display("FAIL fulldrain_count0: got %0d want 4", sb.count); end
        if (sb.st_ready !== 1'b0) begin errors++; $display("FAIL fulldrain_refuse: st_ready=%b want 0", sb.st_ready); end
        tick();
        vectors += 3;
        if (sb.count !== 3'd3)    begin errors++; $display("FAIL fulldrain_count1: got %0d want 3", sb.count); end
        if (sb.st_ready !== 1'b1) begin errors++; $display("FAIL fulldrain_ready1: st_ready=%b want 1", sb.st_ready); end
        if (sb.ld_hit !== 1'b0)   begin errors++; $display("FAIL fulldrain_not_taken: ld_hit=%b want 0", sb.ld_hit); end
        tick();
        sb.st_valid = 1'b0;
        #1;
        vectors += 3;
        if (sb.count !== 3'd3)           begin errors++; $display("FAIL fulldrain_count2: got %0d want 3", sb.count); end
        if (sb.ld_hit !== 1'b1)          begin errors++; $display("FAIL fulldrain_taken_hit: got %b want 1", sb.ld_hit); end
        if (sb.ld_data !== 32'hFEED_0700) begin errors++; $display("FAIL fulldrain_taken_data: got %h want feed0700", sb.ld_data); end
        drain();
        idle_inputs();
    endtask

    task automatic test_youngest_forward();
        logic [31:0] st_a [3] = '{32'h100, 32'h104, 32'h102};
        logic [31:0] st_d [3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] ld_a [5] = '{32'h100, 32'h103, 32'h104, 32'h108, 32'h10C};
        logic        ld_h [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] ld_d [5] = '{32'h33, 32'h33, 32'h22, 32'h0, 32'h0};
        sb.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = st_a[i];
            sb.st_data  = st_d[i];
            sb.st_pc    = 32'h8000 + 32'(4 * i);
            tick();
        end
        sb.st_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.ld_addr = ld_a[i];
            #1;
            vectors += 2;
            if (sb.ld_hit !== ld_h[i]) begin
                errors++; $display("FAIL fwd_hit: ld_addr=%h got %b want %b", ld_a[i], sb.ld_hit, ld_h[i]);
            end
            if (sb.ld_data !== ld_d[i]) begin
                errors++; $display("FAIL fwd_data: ld_addr=%h got %h want %h", ld_a[i], sb.ld_data, ld_d[i]);
            end
        end
        // head 0x100 drains; then 0x104 is at head and being drained while looked up
        sb.dm_ready = 1'b1;
        tick();
        sb.ld_addr = 32'h104;
        #1;
        vectors += 3;
        if (sb.dm_addr !== 32'h104) begin errors++; $display("FAIL fwd_drain_head: dm_addr=%h want 104", sb.dm_addr); end
        if (sb.ld_hit !== 1'b1)     begin errors++; $display("FAIL fwd_drain_hit: got %b want 1", sb.ld_hit); end
        if (sb.ld_data !== 32'h22)  begin errors++; $display("FAIL fwd_drain_data: got %h want 22", sb.ld_data); end
        drain();
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        d           = $urandom;
        sb.dm_ready = 1'b0;
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h200;
        sb.st_data  = d;
        sb.st_pc    = 32'h9000;
        sb.ld_addr  = 32'h200;
        #1;
        vectors += 2;
        if (sb.ld_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_hit: got %b want 0", sb.ld_hit); end
        if (sb.ld_data !== '0)  begin errors++; $display("FAIL same_cycle_data: got %h want 0", sb.ld_data); end
        tick();
        sb.st_valid = 1'b0;
        #1;
        vectors += 2;
        if (sb.ld_hit !== 1'b1) begin errors++; $display("FAIL next_cycle_hit: got %b want 1", sb.ld_hit); end
        if (sb.ld_data !== d)   begin errors++; $display("FAIL next_cycle_data: got %h want %h", sb.ld_data, d); end
        drain();
        idle_inputs();
    endtask

    // Free-running traffic compared cycle by cycle against the queue model.
    // wrap_mode: 10 stores, dm_ready toggling every cycle; otherwise random.
    task automatic run_traffic(input string tag, input int cycles, input bit wrap_mode);
        int          accepted = 0;
        int          max_cnt  = 0;
        st_t         h;
        logic [31:0] ea;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (wrap_mode) begin
                if (accepted >= 10 && model_q.size() == 0) break;
                sb.st_valid = (accepted < 10);
                sb.st_addr  = 32'h800 + 32'(4 * (accepted % 6));
                sb.st_data  = 32'hA000 + 32'(accepted);
                sb.st_pc    = 32'h4000 + 32'(4 * accepted);
                sb.dm_ready = cyc[0];
                sb.ld_addr  = 32'h800 + 32'(4 * $urandom_range(0, 5));
            end else begin
                sb.st_valid = ($urandom_range(0, 3) != 0);
                // a few aliasing addresses differ only above the match window
                sb.st_addr  = 32'h300 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3))
                              + ($urandom_range(0, 4) == 0 ? 32'h1000 : 32'h0);
                sb.st_data  = $urandom;
                sb.st_pc    = $urandom;
                sb.dm_ready = ($urandom_range(0, 2) != 0);
                sb.ld_addr  = 32'h300 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
            end
            #1;
            h  = m_head();
            ea = sb.ld_addr;
            if (int'(sb.count) > max_cnt) max_cnt = int'(sb.count);
            vectors += 9;
            if (sb.count !== CNT_W'(model_q.size())) begin
                errors++; $display("FAIL %s_count: cyc %0d got %0d want %0d", tag, cyc, sb.count, model_q.size());
            end
            if (sb.st_ready !== (model_q.size() < DEPTH)) begin
                errors++; $display("FAIL %s_st_ready: cyc %0d got %b want %b", tag, cyc, sb.st_ready, (model_q.size() < DEPTH));
            end
            if (sb.empty !== (model_q.size() == 0)) begin
                errors++; $display("FAIL %s_empty: cyc %0d got %b want %b", tag, cyc, sb.empty, (model_q.size() == 0));
            end
            if (sb.dm_we !== (model_q.size() != 0)) begin
                errors++; $display("FAIL %s_dm_we: cyc %0d got %b want %b", tag, cyc, sb.dm_we, (model_q.size() != 0));
            end
            if (sb.dm_addr !== h.addr) begin
                errors++; $display("FAIL %s_dm_addr: cyc %0d got %h want %h", tag, cyc, sb.dm_addr, h.addr);
            end
            if (sb.dm_data !== h.data) begin
                errors++; $display("FAIL %s_dm_data: cyc %0d got %h want %h", tag, cyc, sb.dm_data, h.data);
            end
            if (sb.dm_pc !== h.pc) begin
                errors++; $display("FAIL %s_dm_pc: cyc %0d got %h want %h", tag, cyc, sb.dm_pc, h.pc);
            end
            if (sb.ld_hit !== m_hit(ea)) begin
                errors++; $display("FAIL %s_ld_hit: cyc %0d addr %h got %b want %b", tag, cyc, ea, sb.ld_hit, m_hit(ea));
            end
            if (sb.ld_data !== m_data(ea)) begin
                errors++; $display("FAIL %s_ld_data: cyc %0d addr %h got %h want %h", tag, cyc, ea, sb.ld_data, m_data(ea));
            end
            if (sb.st_valid && model_q.size() < DEPTH) accepted++;
            tick();
        end
        vectors++;
        if (max_cnt > DEPTH) begin
            errors++; $display("FAIL %s_max_count: saw %0d want <= %0d", tag, max_cnt, DEPTH);
        end
        if (wrap_mode) begin
            vectors++;
            if (accepted != 10 || model_q.size() != 0) begin
                errors++; $display("FAIL %s_completion: accepted %0d pending %0d want 10 and 0", tag, accepted, model_q.size());
            end
        end
        drain();
        idle_inputs();
    endtask

    task automatic test_write_log();
        vectors++;
        if (wr_act.size() != wr_exp.size()) begin
            errors++; $display("FAIL write_log_len: got %0d writes want %0d", wr_act.size(), wr_exp.size());
        end
        for (int i = 0; i < wr_act.size() && i < wr_exp.size(); i++) begin
            vectors++;
            if (wr_act[i].addr !== wr_exp[i].addr || wr_act[i].data !== wr_exp[i].data ||
                wr_act[i].pc !== wr_exp[i].pc) begin
                errors++;
                $display("FAIL write_log[%0d]: got %h/%h/%h want %h/%h/%h", i,
                         wr_act[i].addr, wr_act[i].data, wr_act[i].pc,
                         wr_exp[i].addr, wr_exp[i].data, wr_exp[i].pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_fill_stall();
        test_full_drain();
        test_youngest_forward();
        test_same_cycle();
        run_traffic("wrap", 100, 1'b1);
        run_traffic("random", 400, 1'b0);
        test_write_log();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_store_buffer
